// File: rtl/bridge_pkg.sv
// Shared command/response codes and state encoding for the serial-to-bus bridge.
package bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_REQ,
        ST_ACCESS,
        ST_RESP
    } state_e;

endpackage

// File: rtl/uart_bus_bridge.sv
// Serial command decoder acting as a second bus master: collects a frame,
// performs one bus access once granted, and streams the response bytes back.
module uart_bus_bridge
    import bridge_pkg::*;
#(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    input  logic [31:0] Read_data,
    output logic        rx_drop
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          is_write_q, is_write_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rsp_q, rsp_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tx_valid_q, tx_valid_d;
    logic          bus_req_q, bus_req_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic          rx_drop_q, rx_drop_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_write_d  = is_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_d       = rsp_q;
        tmo_d       = '0;
        tx_valid_d  = tx_valid_q;
        bus_req_d   = bus_req_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        rx_drop_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    cnt_d = '0;
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        is_write_d = (rx_data == CMD_WRITE);
                        state_d    = ST_ADDR;
                    end else begin
                        rsp_d      = {RSP_ERR, 24'h0};
                        tx_valid_d = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_ADDR, ST_DATA: begin
                // A byte in the expiry cycle wins over the timeout.
                if (rx_valid) begin
                    cnt_d = cnt_q + 2'd1;
                    if (state_q == ST_ADDR) addr_d  = {addr_q[23:0], rx_data};
                    else                    wdata_d = {wdata_q[23:0], rx_data};
                    if (cnt_q == 2'd3) begin
                        if (state_q == ST_ADDR && is_write_q) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d   = ST_REQ;
                            bus_req_d = 1'b1;
                        end
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_REQ: begin
                rx_drop_d = rx_valid;
                if (bus_gnt) begin
                    state_d     = ST_ACCESS;
                    mem_read_d  = ~is_write_q;
                    mem_write_d = is_write_q;
                end
            end
            ST_ACCESS: begin
                rx_drop_d  = rx_valid;
                state_d    = ST_RESP;
                bus_req_d  = 1'b0;
                tx_valid_d = 1'b1;
                cnt_d      = is_write_q ? 2'd0 : 2'd3;
                rsp_d      = is_write_q ? {RSP_ACK, 24'h0} : Read_data;
            end
            ST_RESP: begin
                rx_drop_d = rx_valid;
                if (tx_ready) begin
                    rsp_d = {rsp_q[23:0], 8'h00};
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd0) begin
                        tx_valid_d = 1'b0;
                        cnt_d      = '0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            is_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_q       <= '0;
            tmo_q       <= '0;
            tx_valid_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rx_drop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_write_q  <= is_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_q       <= rsp_d;
            tmo_q       <= tmo_d;
            tx_valid_q  <= tx_valid_d;
            bus_req_q   <= bus_req_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            rx_drop_q   <= rx_drop_d;
        end
    end

    assign tx_data    = rsp_q[31:24];
    assign tx_valid   = tx_valid_q;
    assign bus_req    = bus_req_q;
    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;
    assign Address    = addr_q;
    assign Write_data = wdata_q;
    assign rx_drop    = rx_drop_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Randomised frame-level bench for uart_bus_bridge with a queue-based reference model.
`timescale 1ns/1ps
module tb_uart_bus_bridge;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic        rx_drop;

    logic [31:0] rd_word = 32'h0;
    logic        rd_xor = 1'b0;
    assign Read_data = rd_xor ? (rd_word ^ Address) : rd_word;

    uart_bus_bridge #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Write_data(Write_data), .Read_data(Read_data),
        .rx_drop(rx_drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    op_t        op_q[$];
    logic [7:0] tx_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         drop_exp = 0;
    int         drop_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not expected by model", name);
    endtask

    // Per-cycle monitor against the model queues and protocol rules.
    logic        prev_req_gnt = 1'b0, prev_strobe = 1'b0, prev_hold = 1'b0;
    logic [7:0]  prev_tx = 8'h00;
    logic [31:0] last_tx_word = 32'h0, last_strobe_addr = 32'h0, last_strobe_wdata = 32'h0;
    op_t         mon_op;

    always @(negedge clk) begin
        if (!reset) begin
            prev_req_gnt = 1'b0;
            prev_strobe  = 1'b0;
            prev_hold    = 1'b0;
        end else begin
            if (rx_drop) drop_seen++;
            if (MemRead || MemWrite || prev_req_gnt) begin
                check("strobe_after_grant", {31'h0, MemRead | MemWrite}, {31'h0, prev_req_gnt});
                check("single_strobe", {31'h0, MemRead & MemWrite}, 32'h0);
                check("req_in_access", {31'h0, bus_req}, 32'h1);
            end
            if (MemRead || MemWrite) begin
                last_strobe_addr  = Address;
                last_strobe_wdata = Write_data;
                if (op_q.size() == 0) fail_now("unexpected_strobe");
                else begin
                    mon_op = op_q.pop_front();
                    check("op_is_write", {31'h0, MemWrite}, {31'h0, mon_op.wr});
                    check("op_addr", Address, mon_op.addr);
                    if (mon_op.wr) check("op_wdata", Write_data, mon_op.data);
                end
            end
            if (prev_strobe) begin
                check("txv_after_access", {31'h0, tx_valid}, 32'h1);
                check("req_after_access", {31'h0, bus_req}, 32'h0);
            end
            if (prev_hold) begin
                check("tx_hold_valid", {31'h0, tx_valid}, 32'h1);
                check("tx_hold_data", {24'h0, tx_data}, {24'h0, prev_tx});
            end
            if (tx_valid && tx_ready) begin
                last_tx_word = {last_tx_word[23:0], tx_data};
                if (tx_q.size() == 0) fail_now("unexpected_tx");
                else check("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
            end
            prev_req_gnt = bus_req && bus_gnt && !MemRead && !MemWrite;
            prev_strobe  = MemRead || MemWrite;
            prev_hold    = tx_valid && !tx_ready;
            prev_tx      = tx_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input int gap_lo, input int gap_hi);
        for (int i = 0; i < b.size(); i++) begin
            rx_data  = b[i];
            rx_valid = 1'b1;
            bus_gnt  = 1'($urandom_range(0, 1));
            step();
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            if (i != b.size() - 1) begin
                int g = $urandom_range(gap_lo, gap_hi);
                for (int k = 0; k < g; k++) step();
            end
        end
        bus_gnt = 1'b0;
    endtask

    task automatic maybe_drop(input int drops);
        if (drops == 2 || (drops == 1 && $urandom_range(0, 2) == 0)) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            drop_exp++;
        end
    endtask

    // ready_mode: 0 always ready, 1 random, 2 five low cycles per byte.
    task automatic do_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                            input int gnt_delay, input int gap_lo, input int gap_hi,
                            input int drops, input int ready_mode);
        logic [7:0]  b[$];
        logic [31:0] rdval;
        bit          is_bus;
        int          cyc, low;
        is_bus = (cmd == 8'h57 || cmd == 8'h52);
        b.push_back(cmd);
        if (is_bus) for (int i = 3; i >= 0; i--) b.push_back(addr[8*i +: 8]);
        if (cmd == 8'h57) for (int i = 3; i >= 0; i--) b.push_back(data[8*i +: 8]);
        if (cmd == 8'h57) begin
            op_q.push_back('{1'b1, addr, data});
            tx_q.push_back(8'h4B);
        end else if (cmd == 8'h52) begin
            rdval = rd_xor ? (rd_word ^ addr) : rd_word;
            op_q.push_back('{1'b0, addr, 32'h0});
            for (int i = 3; i >= 0; i--) tx_q.push_back(rdval[8*i +: 8]);
        end else begin
            tx_q.push_back(8'h45);
        end
        send_bytes(b, gap_lo, gap_hi);
        if (is_bus) begin
            check("req_at_last_byte", {31'h0, bus_req}, 32'h1);
            for (int g = 0; g < gnt_delay; g++) begin
                bus_gnt = 1'b0;
                maybe_drop(drops);
                step();
                rx_valid = 1'b0;
            end
            bus_gnt = 1'b1;
            maybe_drop(drops);
            step();
            rx_valid = 1'b0;
            bus_gnt  = 1'($urandom_range(0, 1));
            maybe_drop(drops);
            step();
            rx_valid = 1'b0;
        end
        cyc = 0;
        low = 0;
        while (tx_q.size() > 0 && cyc < 300) begin
            case (ready_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = 1'($urandom_range(0, 1));
                default: begin
                    tx_ready = (low == 5);
                    low = (low == 5) ? 0 : low + 1;
                end
            endcase
            bus_gnt = 1'($urandom_range(0, 1));
            if (drops != 0 && $urandom_range(0, 3) == 0) maybe_drop(2);
            step();
            rx_valid = 1'b0;
            cyc++;
        end
        tx_ready = 1'b0;
        bus_gnt  = 1'b0;
        if (tx_q.size() != 0) begin
            fail_now("response_budget");
            tx_q.delete();
        end
        step();
        step();
        check("drop_count", drop_seen, drop_exp);
        check("ops_pending", op_q.size(), 32'h0);
        check("idle_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("idle_bus_req", {31'h0, bus_req}, 32'h0);
        $display("[TB] frame cmd=%h addr=%h data=%h done", cmd, addr, data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b[$];
        logic [7:0] c;
        reset = 1'b0;
        repeat (3) step();
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_bus_req", {31'h0, bus_req}, 32'h0);
        check("rst_memread", {31'h0, MemRead}, 32'h0);
        check("rst_memwrite", {31'h0, MemWrite}, 32'h0);
        check("rst_address", Address, 32'h0);
        check("rst_wdata", Write_data, 32'h0);
        check("rst_rx_drop", {31'h0, rx_drop}, 32'h0);
        reset = 1'b1;
        step();

        do_frame(8'h57, 32'h0000_0010, 32'h0000_1234, 3, 0, 0, 0, 0);
        check("lit_write_addr", last_strobe_addr, 32'h0000_0010);
        check("lit_write_data", last_strobe_wdata, 32'h0000_1234);
        check("lit_ack", {24'h0, last_tx_word[7:0]}, 32'h4B);

        rd_xor  = 1'b0;
        rd_word = 32'hDEAD_BEEF;
        do_frame(8'h52, 32'h4000_0010, 32'h0, 2, 0, 1, 0, 2);
        check("lit_read_bytes", last_tx_word, 32'hDEAD_BEEF);

        do_frame(8'h99, 32'h0, 32'h0, 0, 0, 0, 0, 1);
        check("lit_err", {24'h0, last_tx_word[7:0]}, 32'h45);

        // Truncated frame followed by a full timeout gap: silently abandoned.
        b = '{8'h52, 8'h00, 8'h00};
        send_bytes(b, 0, 0);
        tx_ready = 1'b1;
        repeat (TMO) step();
        tx_ready = 1'b0;
        check("tmo_no_txv", {31'h0, tx_valid}, 32'h0);
        check("tmo_no_req", {31'h0, bus_req}, 32'h0);
        rd_xor  = 1'b1;
        rd_word = 32'h1357_9BDF;
        do_frame(8'h52, 32'h0000_0004, 32'h0, 1, 0, 2, 0, 0);
        do_frame(8'h57, 32'hA5A5_0001, 32'h0BAD_F00D, 1, TMO - 1, TMO - 1, 0, 0);

        do_frame(8'h57, 32'h0000_0020, 32'hCAFE_0001, 6, 0, 1, 2, 1);
        check("drop_addr_hold", Address, 32'h0000_0020);

        // Reset during REQ must clear bus_req at once and prevent any strobe.
        b = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h30, 8'h11, 8'h22, 8'h33, 8'h44};
        send_bytes(b, 0, 1);
        step();
        check("pre_reset_req", {31'h0, bus_req}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_req", {31'h0, bus_req}, 32'h0);
        check("async_rst_wr", {31'h0, MemWrite}, 32'h0);
        check("async_rst_addr", Address, 32'h0);
        step();
        reset   = 1'b1;
        bus_gnt = 1'b1;
        repeat (5) step();
        bus_gnt = 1'b0;
        check("post_rst_txv", {31'h0, tx_valid}, 32'h0);
        check("post_rst_req", {31'h0, bus_req}, 32'h0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0, 1: c = 8'h57;
                2, 3: c = 8'h52;
                default: begin
                    c = 8'($urandom);
                    if (c == 8'h57 || c == 8'h52) c = 8'h00;
                end
            endcase
            rd_xor  = 1'b1;
            rd_word = $urandom;
            do_frame(c, $urandom, $urandom, $urandom_range(0, 5), 0, 3,
                     $urandom_range(0, 1), $urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

Bus initiator that lets an external host reach the memory-mapped address space (DataMemory, BCD, UART registers) over a serial byte stream. It decodes command frames from a UART receiver's byte output, requests the bus from the CPU-side arbiter, issues exactly one single-cycle MemRead or MemWrite, and returns an acknowledge or read-data bytes to a UART transmitter. It sits beside the CPU as a second master in front of the bus decoder, for boot loading and debug.

## Interface
Parameters:
- TIMEOUT, 1_000_000, maximum idle cycles between bytes of one frame before it is abandoned (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter accepts a byte on a cycle where tx_valid && tx_ready.
- bus_req  out  1  bridge requests bus ownership.
- bus_gnt  in  1  arbiter grant.
- MemRead  out  1  bus read strobe.
- MemWrite  out  1  bus write strobe.
- Address  out  32  bus address.
- Write_data  out  32  bus write data.
- Read_data  in  32  bus read data, combinational from Address.
- rx_drop  out  1  one-cycle pulse when a received byte is discarded.

## Operation
- Frame formats, all multi-byte fields big-endian:
  - Write: 0x57, A3 A2 A1 A0, D3 D2 D1 D0. Response: 0x4B.
  - Read: 0x52, A3 A2 A1 A0. Response: D3 D2 D1 D0.
  - Any other first byte: response 0x45, then return to IDLE.
- States:
  - IDLE: waits for a command byte.
  - ADDR: counts 4 address bytes.
  - DATA: counts 4 data bytes; write only.
  - REQ: bus_req=1, waits for bus_gnt.
  - ACCESS: exactly one cycle.
  - RESP: sends response bytes.
- Transitions:
  - IDLE→ADDR on 0x57 or 0x52.
  - IDLE→RESP on any other byte.
  - ADDR→DATA (write) or ADDR→REQ (read) after the 4th address byte.
  - DATA→REQ after the 4th data byte.
  - REQ→ACCESS on the first cycle bus_gnt is sampled high.
  - ACCESS→RESP.
  - RESP→IDLE when the last response byte is accepted.
- Byte counter: 2 bits, wraps 3→0 at each field boundary.
- Address and write-data registers shift left by 8 on each accepted byte.
- In ACCESS:
  - bus_req remains 1.
  - Exactly one of MemRead or MemWrite is 1.
  - For a read, Read_data is captured into the response shift register at the end of the cycle.
- Outside ACCESS, MemRead and MemWrite are 0. Address and Write_data hold their register values.
- Timeout:
  - A counter runs in ADDR and DATA only, and clears on every rx_valid.
  - On reaching TIMEOUT the frame is abandoned: go to IDLE, send no response.
  - The counter never runs in REQ.
- Bytes are dropped in REQ, ACCESS and RESP. Each dropped byte pulses rx_drop; the frame is not disturbed.
- Reset asserted at any point aborts the transaction immediately. A write strobe in progress is not completed.

## Timing
- Reset values: tx_data=0, tx_valid=0, bus_req=0, MemRead=0, MemWrite=0, Address=0, Write_data=0, rx_drop=0. State is IDLE, counters are 0.
- The last frame byte is accepted at edge N: bus_req=1 from edge N.
- bus_gnt is high in the cycle ending at edge M: ACCESS occupies cycle M..M+1. The strobe is registered, so its latency is one cycle after the grant is sampled.
- bus_req drops at edge M+1. The first tx_valid rises at the same edge.
- Each response byte is held until tx_valid && tx_ready. The next byte, or IDLE, follows at the next edge. There is no bubble between bytes.
- If bus_gnt falls while in REQ, the bridge keeps waiting; grant is only sampled in REQ.
- rx_valid arriving in the same cycle as a timeout expiry: the byte is accepted and the timeout is ignored.

## Structure
- Shared package bridge_pkg holds:
  - CMD_WRITE=8'h57, CMD_READ=8'h52, RSP_ACK=8'h4B, RSP_ERR=8'h45.
  - The state enumeration.
- The module is a single flat RTL block; no sub-module is required.
- The timeout counter width is $clog2(TIMEOUT+1).

## Test plan
- Write frame 57 00 00 00 10 00 00 12 34 with grant after 3 cycles → one MemWrite pulse at Address 0x00000010, Write_data 0x00001234, then tx 0x4B.
- Read frame 52 40 00 00 10 with Read_data=0xDEADBEEF during ACCESS → tx DE AD BE EF in order. With tx_ready low 5 cycles per byte, bytes hold steady.
- Command byte 0x99 → tx 0x45, no bus_req, back to IDLE.
- 52 00 00 followed by a TIMEOUT-cycle gap (TIMEOUT=16 in bench) → no response. The next frame 52 00 00 00 04 completes normally.
- Bytes sent while in REQ with bus_gnt low → rx_drop pulses per byte. Address is unchanged and the transaction completes after grant.
- reset low during REQ → bus_req=0 asynchronously, and no strobe after release.
